// File: rtl/pmu_seq_if.sv
// Power-intent control bundle between the PMU sequencer and its requester/low-power top.
// The slave modport is the sequencer side; the master modport is the requester side.
interface pmu_seq_if #(
    parameter int NDOM = 4
) ();
    logic [NDOM-1:0] sleep_req;
    logic            wake_ovr;
    logic [NDOM-1:0] sleep_mod;
    logic [NDOM-1:0] iso_en;
    logic [NDOM-1:0] save;
    logic [NDOM-1:0] restore;
    logic [NDOM-1:0] dom_on;
    logic            busy;

    modport master (
        output sleep_req, wake_ovr,
        input  sleep_mod, iso_en, save, restore, dom_on, busy
    );

    modport slave (
        input  sleep_req, wake_ovr,
        output sleep_mod, iso_en, save, restore, dom_on, busy
    );
endinterface

// File: rtl/pmu_seq.sv
// Per-domain power sequencer: isolate -> save -> off on the way down, on -> ramp -> restore -> de-isolate up.
// Define PMU_RET_EN to include the retention SAVE/RESTORE steps; otherwise they are skipped and save/restore stay 0.
module pmu_seq #(
    parameter int NDOM    = 4,
    parameter int ISO_CYC = 2,
    parameter int PWR_CYC = 4
) (
    input logic       upf_clk,
    input logic       upf_rst,
    pmu_seq_if.slave  bus
);
    localparam int MAXC = (ISO_CYC > PWR_CYC) ? ISO_CYC : PWR_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ISO_LOAD = CW'(ISO_CYC - 1);
    localparam logic [CW-1:0] PWR_LOAD = CW'(PWR_CYC - 1);

    typedef enum logic [2:0] {
        RUN,
        ISO,
        SAVE,
        OFF,
        PWRUP,
        RESTORE
    } state_e;

    state_e          state_q [NDOM];
    state_e          state_d [NDOM];
    logic [CW-1:0]   cnt_q   [NDOM];
    logic [CW-1:0]   cnt_d   [NDOM];
    logic [NDOM-1:0] reqEff;

    logic [NDOM-1:0] sleepMod_q, sleepMod_d;
    logic [NDOM-1:0] isoEn_q, isoEn_d;
    logic [NDOM-1:0] save_q, save_d;
    logic [NDOM-1:0] restore_q, restore_d;
    logic [NDOM-1:0] domOn_q, domOn_d;
    logic            busy_q, busy_d;

    assign reqEff = bus.sleep_req & ~{NDOM{bus.wake_ovr}};

    always_comb begin
        for (int i = 0; i < NDOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RUN: begin
                    if (reqEff[i]) begin
                        state_d[i] = ISO;
                        cnt_d[i]   = ISO_LOAD;
                    end
                end
                ISO: begin
                    if (!reqEff[i]) begin
                        state_d[i] = RUN;
                    end else if (cnt_q[i] == '0) begin
`ifdef PMU_RET_EN
                        state_d[i] = SAVE;
`else
                        state_d[i] = OFF;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
`ifdef PMU_RET_EN
                SAVE:    state_d[i] = OFF;
                RESTORE: state_d[i] = RUN;
`endif
                OFF: begin
                    if (!reqEff[i]) begin
                        state_d[i] = PWRUP;
                        cnt_d[i]   = PWR_LOAD;
                    end
                end
                PWRUP: begin
                    if (cnt_q[i] == '0) begin
`ifdef PMU_RET_EN
                        state_d[i] = RESTORE;
`else
                        state_d[i] = RUN;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
                default: state_d[i] = RUN;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so every control pin comes straight off a flop.
    always_comb begin
        sleepMod_d = '0;
        isoEn_d    = '0;
        save_d     = '0;
        restore_d  = '0;
        domOn_d    = '0;
        busy_d     = 1'b0;
        for (int i = 0; i < NDOM; i++) begin
            sleepMod_d[i] = (state_d[i] == OFF);
            isoEn_d[i]    = (state_d[i] != RUN);
            domOn_d[i]    = (state_d[i] == RUN);
`ifdef PMU_RET_EN
            save_d[i]     = (state_d[i] == SAVE);
            restore_d[i]  = (state_d[i] == RESTORE);
`endif
            if ((state_d[i] != RUN) && (state_d[i] != OFF)) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge upf_clk) begin
        if (upf_rst) begin
            for (int i = 0; i < NDOM; i++) begin
                state_q[i] <= RUN;
                cnt_q[i]   <= '0;
            end
            sleepMod_q <= '0;
            isoEn_q    <= '0;
            save_q     <= '0;
            restore_q  <= '0;
            domOn_q    <= '1;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NDOM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sleepMod_q <= sleepMod_d;
            isoEn_q    <= isoEn_d;
            save_q     <= save_d;
            restore_q  <= restore_d;
            domOn_q    <= domOn_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sleep_mod = sleepMod_q;
    assign bus.iso_en    = isoEn_q;
    assign bus.save      = save_q;
    assign bus.restore   = restore_q;
    assign bus.dom_on    = domOn_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pmu_seq.sv
// Testbench for pmu_seq: directed vector table, hand-written override/reset sequences, and random traffic
// checked against an elapsed-time model of each domain's power sequence.
module tb_pmu_seq;
    localparam int NDOM    = 4;
    localparam int ISO_CYC = 2;
    localparam int PWR_CYC = 4;
`ifdef PMU_RET_EN
    localparam int RET = 1;
`else
    localparam int RET = 0;
`endif

    logic upf_clk = 1'b0;
    logic upf_rst = 1'b1;

    pmu_seq_if #(.NDOM(NDOM)) bus ();

    pmu_seq #(
        .NDOM   (NDOM),
        .ISO_CYC(ISO_CYC),
        .PWR_CYC(PWR_CYC)
    ) dut (
        .upf_clk(upf_clk),
        .upf_rst(upf_rst),
        .bus    (bus)
    );

    always #5 upf_clk = ~upf_clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = up, 1 = going down, 2 = down, 3 = coming up; elapsed counts edges since phase entry.
    int phase   [NDOM];
    int elapsed [NDOM];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       wake;
        logic [3:0] sm;
        logic [3:0] iso;
        logic [3:0] sv;
        logic [3:0] rs;
        logic [3:0] on;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic rst, input logic [NDOM-1:0] req, input logic wake);
        for (int i = 0; i < NDOM; i++) begin
            logic r;
            r = req[i] & ~wake;
            if (rst) begin
                phase[i]   = 0;
                elapsed[i] = 0;
            end else begin
                case (phase[i])
                    0: if (r) begin phase[i] = 1; elapsed[i] = 0; end
                    1: begin
                        if (!r && elapsed[i] < ISO_CYC) begin
                            phase[i] = 0;
                        end else begin
                            elapsed[i]++;
                            if (elapsed[i] == ISO_CYC + RET) phase[i] = 2;
                        end
                    end
                    2: if (!r) begin phase[i] = 3; elapsed[i] = 0; end
                    default: begin
                        elapsed[i]++;
                        if (elapsed[i] == PWR_CYC + RET) phase[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic modelOutputs(output logic [NDOM-1:0] sm, output logic [NDOM-1:0] iso,
                                output logic [NDOM-1:0] sv, output logic [NDOM-1:0] rs,
                                output logic [NDOM-1:0] on, output logic busy);
        busy = 1'b0;
        for (int i = 0; i < NDOM; i++) begin
            sm[i]  = (phase[i] == 2);
            iso[i] = (phase[i] != 0);
            on[i]  = (phase[i] == 0);
            sv[i]  = (RET == 1) && (phase[i] == 1) && (elapsed[i] == ISO_CYC);
            rs[i]  = (RET == 1) && (phase[i] == 3) && (elapsed[i] == PWR_CYC);
            if (phase[i] == 1 || phase[i] == 3) busy = 1'b1;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then compare just after the edge.
    task automatic applyStimulus(input logic rst, input logic [NDOM-1:0] req, input logic wake);
        logic [NDOM-1:0] sm, iso, sv, rs, on;
        logic busy;
        upf_rst       = rst;
        bus.sleep_req = req;
        bus.wake_ovr  = wake;
        @(posedge upf_clk);
        modelStep(rst, req, wake);
        #1;
        modelOutputs(sm, iso, sv, rs, on, busy);
        checkOutput("model sleep_mod", 32'(bus.sleep_mod), 32'(sm));
        checkOutput("model iso_en",    32'(bus.iso_en),    32'(iso));
        checkOutput("model save",      32'(bus.save),      32'(sv));
        checkOutput("model restore",   32'(bus.restore),   32'(rs));
        checkOutput("model dom_on",    32'(bus.dom_on),    32'(on));
        checkOutput("model busy",      32'(bus.busy),      32'(busy));
        checkOutput("inv sleep_mod without iso", 32'(bus.sleep_mod & ~bus.iso_en), 32'd0);
        checkOutput("inv save and restore",      32'(bus.save & bus.restore),      32'd0);
        checkOutput("inv pulse while off",       32'((bus.save | bus.restore) & bus.sleep_mod), 32'd0);
    endtask

    task automatic addVec(input logic rst, input logic [3:0] req, input logic wake,
                          input logic [3:0] sm, input logic [3:0] iso, input logic [3:0] sv,
                          input logic [3:0] rs, input logic [3:0] on, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.wake = wake;
        v.sm = sm; v.iso = iso; v.sv = sv; v.rs = rs; v.on = on; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("vec%0d sleep_mod", idx), 32'(bus.sleep_mod), 32'(v.sm));
        checkOutput($sformatf("vec%0d iso_en", idx),    32'(bus.iso_en),    32'(v.iso));
        checkOutput($sformatf("vec%0d save", idx),      32'(bus.save),      32'(v.sv));
        checkOutput($sformatf("vec%0d restore", idx),   32'(bus.restore),   32'(v.rs));
        checkOutput($sformatf("vec%0d dom_on", idx),    32'(bus.dom_on),    32'(v.on));
        checkOutput($sformatf("vec%0d busy", idx),      32'(bus.busy),      32'(v.busy));
    endtask

    initial begin
        logic [3:0] rq;
        logic       wk;
        logic       rs;
        logic       r1 = (RET == 1);

        bus.sleep_req = '0;
        bus.wake_ovr  = 1'b0;

        // Reset, domain 0 down/up, domain 1 abort.
        addVec(1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
        addVec(1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
        addVec(0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
        addVec(0, 4'h1, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h1, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h1, 0, r1 ? 4'h0 : 4'h1, 4'h1, r1 ? 4'h1 : 4'h0, 4'h0, 4'hE, r1);
        addVec(0, 4'h1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'hE, 0);
        addVec(0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE, 1);
        addVec(0, 4'h0, 0, 4'h0, r1 ? 4'h1 : 4'h0, 4'h0, r1 ? 4'h1 : 4'h0, r1 ? 4'hE : 4'hF, r1);
        addVec(0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
        addVec(0, 4'h2, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'hD, 1);
        addVec(0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
        addVec(0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].wake);
            checkVec(i, tbl[i]);
        end

        // Wake override pulls domains 2 and 3 out of OFF and keeps them up while held.
        for (int k = 0; k < ISO_CYC + RET + 2; k++) applyStimulus(0, 4'hC, 0);
        checkOutput("ovr off sleep_mod", 32'(bus.sleep_mod), 32'hC);
        applyStimulus(0, 4'hC, 1);
        checkOutput("ovr first sleep_mod", 32'(bus.sleep_mod), 32'h0);
        checkOutput("ovr first iso_en",    32'(bus.iso_en),    32'hC);
        for (int k = 1; k < PWR_CYC + RET; k++) begin
            applyStimulus(0, 4'hC, 1);
            checkOutput($sformatf("ovr ramp%0d dom_on", k), 32'(bus.dom_on), 32'h3);
        end
        applyStimulus(0, 4'hC, 1);
        checkOutput("ovr up dom_on", 32'(bus.dom_on), 32'hF);
        checkOutput("ovr up iso_en", 32'(bus.iso_en), 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 4'hC, 1);
            checkOutput($sformatf("ovr hold%0d iso_en", k), 32'(bus.iso_en), 32'h0);
        end
        applyStimulus(0, 4'h0, 0);

        // Reset in the middle of power-up returns everything to reset values.
        for (int k = 0; k < ISO_CYC + RET + 1; k++) applyStimulus(0, 4'h1, 0);
        checkOutput("rst pre sleep_mod", 32'(bus.sleep_mod), 32'h1);
        applyStimulus(0, 4'h0, 0);
        applyStimulus(0, 4'h0, 0);
        checkOutput("rst pwrup iso_en", 32'(bus.iso_en), 32'h1);
        applyStimulus(1, 4'h0, 0);
        checkOutput("rst mid sleep_mod", 32'(bus.sleep_mod), 32'h0);
        checkOutput("rst mid iso_en",    32'(bus.iso_en),    32'h0);
        checkOutput("rst mid dom_on",    32'(bus.dom_on),    32'hF);
        checkOutput("rst mid busy",      32'(bus.busy),      32'h0);

        // Random traffic against the model.
        rq = 4'h0;
        wk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
            if ($urandom_range(0, 39) == 0) wk = ~wk;
            rs = ($urandom_range(0, 299) == 0);
            applyStimulus(rs, rq, wk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
